// File: rtl/filter_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | filter_irq_ctrl                                                            |
// | Aggregates per-channel filter events into sticky status, saturating event  |
// | counters and a single CPU interrupt with post-acknowledge holdoff.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module filter_irq_ctrl #(
  parameter int NUM_CH  = 8,
  parameter int HOLDOFF = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] filt_int_i,
  input  logic [NUM_CH-1:0] filt_data_i,
  input  logic [NUM_CH-1:0] int_mask_i,
  input  logic              clr_en_i,
  input  logic [NUM_CH-1:0] clr_mask_i,
  input  logic              irq_ack_i,
  input  logic [3:0]        cnt_sel_i,
  input  logic              cnt_clr_i,
  output logic [NUM_CH-1:0] int_status_o,
  output logic [NUM_CH-1:0] level_o,
  output logic [7:0]        cnt_o,
  output logic [NUM_CH-1:0] cnt_ovf_o,
  output logic              irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Loading HOLDOFF-1 and leaving on zero gives exactly HOLDOFF cycles in HOLD.
  localparam logic [3:0] C_HOLD_LOAD = 4'(HOLDOFF - 1);

  logic [NUM_CH-1:0] status_q, status_d;
  logic [NUM_CH-1:0] level_q,  level_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  state_t            state_q, state_d;
  logic              irq_q, irq_d;
  logic              pending;
  logic [7:0]        cnt_all [NUM_CH];

  always_comb begin
    status_d = status_q;
    if (clr_en_i) status_d = status_d & ~clr_mask_i;
    status_d = status_d | filt_int_i;
    level_d  = filt_data_i;
    pending  = |(status_q & int_mask_i);
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pending) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (irq_ack_i) begin
          state_d    = ST_HOLD;
          hold_cnt_d = C_HOLD_LOAD;
        end else if (!pending) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == 4'd0) state_d = ST_IDLE;
        else                    hold_cnt_d = hold_cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    irq_d = (state_d == ST_ASSERT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q   <= '0;
      level_q    <= '0;
      hold_cnt_q <= 4'd0;
      state_q    <= ST_IDLE;
      irq_q      <= 1'b0;
    end else begin
      status_q   <= status_d;
      level_q    <= level_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
      irq_q      <= irq_d;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [7:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;
    logic       clr_hit;

    // A clear and a same-cycle pulse combine into a count of one.
    always_comb begin
      clr_hit = cnt_clr_i && (cnt_sel_i == 4'(n));
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (clr_hit) begin
        cnt_d = filt_int_i[n] ? 8'd1 : 8'd0;
        ovf_d = 1'b0;
      end else if (filt_int_i[n]) begin
        if (cnt_q == 8'hFF) ovf_d = 1'b1;
        else                cnt_d = cnt_q + 8'd1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= 8'd0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign cnt_all[n]   = cnt_q;
    assign cnt_ovf_o[n] = ovf_q;
  end

  always_comb begin
    cnt_o = 8'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_sel_i == 4'(i)) cnt_o = cnt_all[i];
    end
  end

  assign int_status_o = status_q;
  assign level_o      = level_q;
  assign irq_o        = irq_q;

endmodule
`default_nettype wire
